// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: start-up fill, load-use bubble, redirect flush, memory-wait freeze.
// Latency: control outputs are combinational from state and inputs; state and perf counters update on the next Clk edge.
// Backpressure: Dmem_Busy freezes PC, IF/ID, ID/EX and EX/MEM, and the REDIRECT countdown, until memory is ready.
module hazard_control_unit #(
  parameter int STARTUP_CYCLES = 2,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_W          = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             Rs1_Valid_ID,
  input  logic             Rs2_Valid_ID,
  input  logic [4:0]       rd_EX,
  input  logic             Write_Enable_EX,
  input  logic             I_Type_Load_EX,
  input  logic             Redirect_EX,
  input  logic             Dmem_Busy,
  output logic             PC_Stall,
  output logic             PC_Redirect_Sel,
  output logic             IF_ID_Stall,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Stall,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Stall,
  output logic [1:0]       Ctrl_State,
  output logic [CNT_W-1:0] Stall_Cycle_Count,
  output logic [CNT_W-1:0] Flush_Event_Count
);

  localparam logic [1:0] ST_STARTUP  = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT = 2'd3;

  localparam logic [3:0]       START_LOAD   = 4'(STARTUP_CYCLES);
  localparam logic [3:0]       FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [1:0] state;
  logic [1:0] ret_state;
  logic [1:0] eff_state;
  logic [3:0] cnt;
  logic       load_use;
  logic       flush_evt;

  // Load in EX whose destination is read by the instruction in ID; x0 never hazards.
  always_comb begin
    load_use = I_Type_Load_EX & Write_Enable_EX & (rd_EX != 5'd0) &
               ((Rs1_Valid_ID & (rs1_ID == rd_EX)) | (Rs2_Valid_ID & (rs2_ID == rd_EX)));
  end

  // Leaving MEM_WAIT behaves exactly like the return-state in the same cycle.
  always_comb begin
    eff_state = ((state == ST_MEM_WAIT) && !Dmem_Busy) ? ret_state : state;
  end

  // Pipeline controls, Dmem_Busy > Redirect_EX > REDIRECT flushing > load-use.
  always_comb begin
    PC_Stall        = 1'b0;
    PC_Redirect_Sel = 1'b0;
    IF_ID_Stall     = 1'b0;
    IF_ID_Flush     = 1'b0;
    ID_EX_Stall     = 1'b0;
    ID_EX_Flush     = 1'b0;
    EX_MEM_Stall    = 1'b0;
    flush_evt       = 1'b0;
    case (eff_state)
      ST_STARTUP: begin
        PC_Stall    = 1'b1;
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end
      ST_RUN, ST_REDIRECT: begin
        if (Dmem_Busy) begin
          PC_Stall     = 1'b1;
          IF_ID_Stall  = 1'b1;
          ID_EX_Stall  = 1'b1;
          EX_MEM_Stall = 1'b1;
        end else if (Redirect_EX) begin
          PC_Redirect_Sel = 1'b1;
          IF_ID_Flush     = 1'b1;
          ID_EX_Flush     = 1'b1;
          flush_evt       = 1'b1;
        end else if (eff_state == ST_REDIRECT) begin
          // ID holds a wrong-path instruction, so load-use is not considered.
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
        end else if (load_use) begin
          PC_Stall    = 1'b1;
          IF_ID_Stall = 1'b1;
          ID_EX_Flush = 1'b1;
          flush_evt   = 1'b1;
        end
      end
      default: begin
        PC_Stall     = 1'b1;
        IF_ID_Stall  = 1'b1;
        ID_EX_Stall  = 1'b1;
        EX_MEM_Stall = 1'b1;
      end
    endcase
  end

  // Sequencer state, countdown and return-state bookkeeping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_STARTUP;
      cnt       <= START_LOAD;
      ret_state <= ST_RUN;
    end else begin
      case (eff_state)
        ST_STARTUP: begin
          if (cnt <= 4'd1) state <= ST_RUN;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RUN, ST_REDIRECT: begin
          if (Dmem_Busy) begin
            state     <= ST_MEM_WAIT;
            ret_state <= eff_state;
          end else if (Redirect_EX) begin
            cnt   <= FLUSH_RELOAD;
            state <= (FLUSH_CYCLES == 1) ? ST_RUN : ST_REDIRECT;
          end else if (eff_state == ST_REDIRECT) begin
            if (cnt <= 4'd1) begin
              state <= ST_RUN;
            end else begin
              state <= ST_REDIRECT;
              cnt   <= cnt - 4'd1;
            end
          end else begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_MEM_WAIT;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Stall_Cycle_Count <= '0;
      Flush_Event_Count <= '0;
    end else begin
      if (PC_Stall && (Stall_Cycle_Count != CNT_MAX))
        Stall_Cycle_Count <= Stall_Cycle_Count + 1'b1;
      if (flush_evt && (Flush_Event_Count != CNT_MAX))
        Flush_Event_Count <= Flush_Event_Count + 1'b1;
    end
  end

  assign Ctrl_State = state;

endmodule
